uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that responds to the RISCV core's data-memory bus. The core writes bytes to a data register; the block queues them in a small FIFO and serialises them 8N1, LSB first, on `tx_o`. A status register lets firmware poll for space and completion. It sits beside data memory on the core's load/store path and gives test programs an observable output channel.

---
 rtl/uart_tx_mmio.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// DATA register at BASE_ADDR (write pushes a byte), STATUS at BASE_ADDR+4
// reads {28'b0, overflow, busy, empty, full}; reading STATUS clears overflow.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // Even parity over one byte.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity;
  logic          overflow;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic          sel_data;
  logic          sel_status;
  logic          data_wr;
  logic          status_rd;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          ovf_event;
  logic          baud_end;
  logic [7:0]    head;
  logic          unused_bits;

  assign sel_data   = (address_i == BASE_ADDR);
  assign sel_status = (address_i == (BASE_ADDR + 32'd4));
  assign data_wr    = mem_write_i && sel_data;
  assign status_rd  = mem_read_i && sel_status;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push      = data_wr && !full;
  assign ovf_event = data_wr && full;
  assign baud_end  = (baud == BAUD_MAX);
  assign head      = fifo_mem[rptr[AW-1:0]];
  // The FSM takes the head byte from IDLE, or straight from the end of STOP
  // so back-to-back frames have no gap.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_end));

`ifdef UART_TX_PARITY_EN
  assign unused_bits = ^write_data_i[31:8];
`else
  assign unused_bits = ^{write_data_i[31:8], parity};
`endif

  // Busy whenever a byte is waiting or a frame is on the line.
  always_comb begin
    busy_o = !empty || (state != IDLE);
  end

  // Load-data mux: only STATUS returns anything non-zero.
  always_comb begin
    read_data_o = 32'd0;
    if (status_rd) begin
      read_data_o = {28'd0, overflow, busy_o, empty, full};
    end else begin
      read_data_o = 32'd0;
    end
  end

  // FIFO pointers and storage; fullness is judged on the pre-edge pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 8'd0;
      end
    end else begin
      if (push) begin
        fifo_mem[wptr[AW-1:0]] <= write_data_i[7:0];
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow: a dropped byte wins over a same-edge clearing read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (status_rd) begin
      overflow <= 1'b0;
    end
  end

  // Serialiser FSM with registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      parity  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= 3'd0;
          if (pop) begin
            shift  <= head;
            parity <= even_parity(head);
            state  <= START;
            tx_o   <= 1'b0;
          end else begin
            tx_o   <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            state <= DATA;
            tx_o  <= shift[0];
          end else begin
            baud  <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_o    <= parity;
`else
              state   <= STOP;
              tx_o    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_o    <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            state <= STOP;
            tx_o  <= 1'b1;
          end else begin
            baud  <= baud + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              shift  <= head;
              parity <= even_parity(head);
              state  <= START;
              tx_o   <= 1'b0;
            end else begin
              state  <= IDLE;
              tx_o   <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          tx_o    <= 1'b1;
          baud    <= '0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: register-access vector table, hand-written
// frame sequences and randomized traffic against a line-level reference model.
module tb_uart_tx_mmio;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE   = 32'h1001_0024;
  localparam logic [31:0] STATUS = 32'h1001_0028;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        tx;
  logic        busy;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .mem_write_i(mem_write), .mem_read_i(mem_read),
    .address_i(address), .write_data_i(write_data), .read_data_o(read_data),
    .tx_o(tx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: byte queue, expected line waveform (one entry per cycle),
  // sticky overflow flag and the list of bytes that were put on the line.
  logic [7:0] m_fifo [$];
  logic       m_line [$];
  logic       m_ovf = 1'b0;
  logic [7:0] sent_q [$];

  // Passive serial receiver output.
  logic [7:0] rx_data [$];
  logic       rx_par  [$];
  logic       rx_stop [$];

  // Transition log of tx, for timing checks.
  int   tr [$];
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;
  int   busy_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 32'h%08h expected 32'h%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_busy();
    return (m_fifo.size() != 0) || (m_line.size() != 0);
  endfunction

  function automatic logic [31:0] m_status();
    return {28'd0, m_ovf, m_busy(), m_fifo.size() == 0, m_fifo.size() == DEPTH};
  endfunction

  task automatic model_frame(input logic [7:0] b);
    logic fb [$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    fb.push_back(^b);
`endif
    fb.push_back(1'b1);
    foreach (fb[k]) for (int j = 0; j < CPB; j++) m_line.push_back(fb[k]);
    sent_q.push_back(b);
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data);
    int  pre_size;
    logic wr_data;
    pre_size = m_fifo.size();
    wr_data  = wr && (addr == BASE);
    if (m_line.size() != 0) void'(m_line.pop_front());
    if (m_line.size() == 0 && pre_size != 0) model_frame(m_fifo.pop_front());
    if (wr_data && pre_size == DEPTH) m_ovf = 1'b1;
    else if (rd && addr == STATUS) m_ovf = 1'b0;
    if (wr_data && pre_size != DEPTH) m_fifo.push_back(data[7:0]);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
    m_ovf = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check load data, clock, check line/busy.
  task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata);
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_write = wr; mem_read = rd; address = addr; write_data = data;
    #1;
    exp_rd = (rd && addr == STATUS) ? m_status() : 32'd0;
    rdata  = read_data;
    check("read_data", read_data, exp_rd);
    @(posedge clk);
    model_edge(wr, rd, addr, data);
    cyc++;
    #1;
    check("tx", {31'd0, tx}, {31'd0, (m_line.size() != 0) ? m_line[0] : 1'b1});
    check("busy", {31'd0, busy}, {31'd0, m_busy()});
    if (tx != prev_tx) tr.push_back(cyc);
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_tx = tx;
    prev_busy = busy;
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, rd);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] rd;
    int n;
    n = 0;
    while ((busy || m_busy()) && n < budget) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, rd);
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
    idle(2);
  endtask

  task automatic clear_logs();
    rx_data.delete(); rx_par.delete(); rx_stop.delete();
    sent_q.delete(); tr.delete();
  endtask

  // Serial receiver: samples each bit at its centre.
  initial begin
    logic [7:0] b;
    logic p, s;
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) begin
        for (int j = 0; j < CPB / 2; j++) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < CPB; j++) @(negedge clk);
          b[i] = tx;
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        for (int j = 0; j < CPB; j++) @(negedge clk);
        p = tx;
`endif
        for (int j = 0; j < CPB; j++) @(negedge clk);
        s = tx;
        rx_data.push_back(b); rx_par.push_back(p); rx_stop.push_back(s);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    int cs;
    int r;

    vecs[0] = '{1'b0, 1'b1, STATUS,           32'd0,        32'h2, 1'b0};
    vecs[1] = '{1'b0, 1'b1, BASE,             32'd0,        32'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, STATUS,           32'd0,        32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, STATUS,           32'h55,       32'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, STATUS,           32'd0,        32'h2, 1'b0};
    vecs[5] = '{1'b1, 1'b0, BASE + 32'd8,     32'h77,       32'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, BASE + 32'd8,     32'd0,        32'h0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, BASE - 32'd4,     32'd0,        32'h0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, BASE + 32'd1,     32'h99,       32'h0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, STATUS,           32'd0,        32'h2, 1'b0};

    // Reset held low.
    #12;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Register-access table.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end
    clear_logs();

    // Single byte 8'hA5.
    step(1'b1, 1'b0, BASE, 32'hA5, rd);
    cs = cyc;
    check("a5_busy_after_store", {31'd0, busy}, 32'd1);
    wait_idle(400);
    check("a5_fall", 32'(tr.size() > 0 ? tr[0] : 0), 32'(cs + 1));
    check("a5_start_len", 32'(tr.size() > 1 ? tr[1] - tr[0] : 0), 32'(CPB));
    check("a5_frame_len", 32'(busy_fall_cyc - (tr.size() > 0 ? tr[0] : 0)), 32'(FRAME_BITS * CPB));
    check("a5_rx_count", 32'(rx_data.size()), 32'd1);
    check("a5_rx_byte", {24'd0, rx_data.size() > 0 ? rx_data[0] : 8'd0}, 32'hA5);
    check("a5_rx_stop", {31'd0, rx_stop.size() > 0 ? rx_stop[0] : 1'b0}, 32'd1);
    clear_logs();

    // Four consecutive stores: contiguous frames, in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, BASE, 32'(i), rd);
    wait_idle(1200);
    check("four_len", 32'(busy_fall_cyc - (tr.size() > 0 ? tr[0] : 0)), 32'(4 * FRAME_BITS * CPB));
    check("four_rx_count", 32'(rx_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_data.size(); i++)
      check($sformatf("four_rx%0d", i), {24'd0, rx_data[i]}, 32'(i + 1));
    clear_logs();

    // Six stores: one popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, BASE, 32'h11 + 32'(i), rd);
    step(1'b0, 1'b1, STATUS, 32'd0, rd);
    check("six_status", rd, 32'hD);
    step(1'b0, 1'b1, STATUS, 32'd0, rd);
    check("six_status_cleared", rd, 32'h5);
    wait_idle(1200);
    check("six_rx_count", 32'(rx_data.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_data.size(); i++)
      check($sformatf("six_rx%0d", i), {24'd0, rx_data[i]}, 32'h11 + 32'(i));
    clear_logs();

    // Reset in the middle of the third data bit, with a second byte queued.
    step(1'b1, 1'b0, BASE, 32'h5A, rd);
    cs = cyc;
    step(1'b1, 1'b0, BASE, 32'h3C, rd);
    while (cyc < cs + 1 + 2 * CPB + CPB + CPB / 2) idle(1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    prev_tx = tx;
    prev_busy = busy;
    tr.delete();
    step(1'b0, 1'b1, STATUS, 32'd0, rd);
    check("postreset_status", rd, 32'h2);
    idle(300);
    check("postreset_no_frame", 32'(tr.size()), 32'd0);
    clear_logs();

    // Parity / framing for 8'h07 and 8'h03.
    step(1'b1, 1'b0, BASE, 32'h07, rd);
    wait_idle(400);
    check("b07_len", 32'(busy_fall_cyc - (tr.size() > 0 ? tr[0] : 0)), 32'(FRAME_BITS * CPB));
    check("b07_rx", {24'd0, rx_data.size() > 0 ? rx_data[0] : 8'd0}, 32'h07);
`ifdef UART_TX_PARITY_EN
    check("b07_parity", {31'd0, rx_par.size() > 0 ? rx_par[0] : 1'b0}, 32'd1);
`endif
    clear_logs();
    step(1'b1, 1'b0, BASE, 32'h03, rd);
    wait_idle(400);
    check("b03_rx", {24'd0, rx_data.size() > 0 ? rx_data[0] : 8'hFF}, 32'h03);
`ifdef UART_TX_PARITY_EN
    check("b03_parity", {31'd0, rx_par.size() > 0 ? rx_par[0] : 1'b1}, 32'd0);
`endif
    clear_logs();

    // Randomized bus traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    step(1'b1, 1'b0, BASE, $urandom, rd);
        2:       step(1'b1, 1'b0, BASE, $urandom, rd);
        3:       step(1'b0, 1'b1, STATUS, 32'd0, rd);
        4:       step(1'b1, 1'b0, STATUS, $urandom, rd);
        5:       step(1'b0, 1'b1, BASE, 32'd0, rd);
        6:       step(1'b1, 1'b1, BASE + 32'd12, $urandom, rd);
        default: step(1'b0, 1'b0, 32'd0, 32'd0, rd);
      endcase
    end
    wait_idle(4000);
    check("rand_rx_count", 32'(rx_data.size()), 32'(sent_q.size()));
    for (int i = 0; i < rx_data.size() && i < sent_q.size(); i++) begin
      check($sformatf("rand_rx%0d", i), {24'd0, rx_data[i]}, {24'd0, sent_q[i]});
      check($sformatf("rand_stop%0d", i), {31'd0, rx_stop[i]}, 32'd1);
`ifdef UART_TX_PARITY_EN
      check($sformatf("rand_par%0d", i), {31'd0, rx_par[i]}, {31'd0, ^sent_q[i]});
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
